// File: rtl/btn_pkg.sv
// Shared definitions for the button debounce / pulse-select block:
// debounce FSM state encoding, default debounce length and a helper
// that sizes the stability counter.
package btn_pkg;

  // 10 ms of stable input at a 100 MHz system clock
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

  // Two-bit encoding of the debounce FSM states
  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  typedef enum logic [1:0] {
    IDLE         = ST_IDLE,
    PRESS_WAIT   = ST_PRESS_WAIT,
    PRESSED      = ST_PRESSED,
    RELEASE_WAIT = ST_RELEASE_WAIT
  } btn_state_t;

  // Counter width for a debounce length of n cycles. A length of 1 still
  // needs one bit so the counter and its terminal value stay legal vectors.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : btn_pkg

// File: rtl/btn_debounce.sv
// One raw push button: synchronizer chain, stability counter and a
// four-state debounce FSM. Produces the registered debounced level and a
// registered one-cycle press pulse on each accepted press.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   in_sync;
  logic [CNT_W-1:0]       cnt;
  btn_state_t             state;

  // Synchronizer chain bringing the asynchronous button into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync[i] <= sync[i-1];
      end
    end
  end

  assign in_sync = sync[SYNC_STAGES-1];

  // Debounce FSM: a level change is accepted only after DEBOUNCE_CYCLES
  // consecutive stable samples; level and press are registered here so
  // the press pulse lands in the cycle right after the acceptance edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      case (state)
        IDLE: begin
          if (in_sync) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!in_sync) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state <= PRESSED;
            cnt   <= '0;
            level <= 1'b1;
            press <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!in_sync) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          // A bounce back to 1 returns to PRESSED silently: the press was
          // already reported, so no second pulse and level stays high.
          if (in_sync) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          level <= 1'b0;
        end
      endcase
    end
  end

endmodule : btn_debounce

// File: rtl/button_pulse_sel.sv
// Two debounced buttons driving a downstream 1-to-4 demultiplexer:
// btnC presses become single-cycle data pulses, btnU presses advance the
// 2-bit channel select modulo 4.
module button_pulse_sel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btnC,
  input  logic       btnU,
  output logic       data,
  output logic [1:0] sel,
  output logic       btnC_level
);

  logic c_level;
  logic c_press;
  logic u_press;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_btn_c (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btnC),
    .level (c_level),
    .press (c_press)
  );

  // Only the press pulse of the select button matters; its level is unused.
  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SYNC_STAGES     (SYNC_STAGES)
  ) u_btn_u (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btnU),
    .level (),
    .press (u_press)
  );

  // The debounce flops already hold the registered pulse and level, so
  // the outputs come straight from them without adding a cycle.
  assign data       = c_press;
  assign btnC_level = c_level;

  // Channel select advances on the registered btnU pulse, so a coincident
  // btnC pulse still sees the old select and the new value appears a cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel <= 2'b00;
    end else if (u_press) begin
      sel <= sel + 2'd1;
    end
  end

endmodule : button_pulse_sel

// File: doc/button_pulse_sel.md
BUTTON_PULSE_SEL -- requirements
Module: button_pulse_sel

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning consecutive stable cycles required to accept a level change (10 ms at 100 MHz).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer flop depth per raw button input.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port btnC  input  1  raw, asynchronous, bouncing data button.
REQ-006 SHALL have port btnU  input  1  raw, asynchronous, bouncing select-advance button.
REQ-007 SHALL have port data  output  1  registered single-cycle pulse per accepted btnC press; feeds the downstream 1-to-4 demultiplexer data input.
REQ-008 SHALL have port sel  output  2  registered channel select; feeds the downstream demultiplexer sel input.
REQ-009 SHALL have port btnC_level  output  1  registered debounced btnC level.

Function
REQ-010 SHALL pass each raw button through SYNC_STAGES flops before any other logic uses it.
REQ-011 SHALL run one debounce FSM per button with states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-012 SHALL move IDLE->PRESS_WAIT on synchronized input 1 and clear the stability counter.
REQ-013 SHALL, in PRESS_WAIT, increment the counter each cycle input is 1, go to PRESSED when input is 1 and counter equals DEBOUNCE_CYCLES-1, and return to IDLE on any cycle input is 0.
REQ-014 SHALL move PRESSED->RELEASE_WAIT on synchronized input 0 and clear the counter.
REQ-015 SHALL, in RELEASE_WAIT, go to IDLE when input is 0 and counter equals DEBOUNCE_CYCLES-1, and return to PRESSED without a pulse on any cycle input is 1.
REQ-016 SHALL assert the per-button press pulse for exactly one cycle, in the cycle after the PRESS_WAIT->PRESSED transition edge.
REQ-017 SHALL produce data high first in the cycle after edge SYNC_STAGES+1+DEBOUNCE_CYCLES, counting edge 1 as the first edge sampling btnC high (steady input).
REQ-018 SHALL produce exactly one data pulse per press regardless of hold duration; no auto-repeat.
REQ-019 SHALL assert btnC_level 1 in states PRESSED and RELEASE_WAIT, 0 otherwise.
REQ-020 SHALL increment sel by 1 modulo 4 on each btnU press pulse; 2'b11 wraps to 2'b00.
REQ-021 SHALL, when btnU and btnC pulses coincide, keep the pre-increment sel valid during the data pulse cycle; sel updates the following cycle.
REQ-022 SHALL size the counter as clog2(DEBOUNCE_CYCLES) bits and never let it exceed DEBOUNCE_CYCLES-1.
REQ-023 SHALL treat DEBOUNCE_CYCLES=1 as acceptance on the first cycle in PRESS_WAIT/RELEASE_WAIT.

Reset
REQ-024 SHALL, while rst_n=0, immediately force data=0, sel=2'b00, btnC_level=0, all FSMs IDLE, counters 0, synchronizer flops 0.
REQ-025 SHALL discard any in-progress debounce when reset asserts mid-operation; a button held through reset release produces one pulse after a full fresh debounce.
REQ-026 SHALL emit no pulse in the first cycle after reset release.

Structure
REQ-027 SHALL place the FSM state encoding (2-bit localparams) and default DEBOUNCE_CYCLES in shared package btn_pkg.
REQ-028 SHALL implement synchronizer, counter and FSM as sub-module btn_debounce (outputs: level, press pulse), instantiated twice.
REQ-029 SHALL keep the sel counter and output registers in button_pulse_sel top.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-030 SHALL check: btnC steady high from edge 1 -> data=1 only in the cycle after edge 7; btnC_level=1 from the same cycle.
REQ-031 SHALL check: btnC toggled 1,0,1,0 on consecutive cycles then held 1 -> no pulse until 4 stable cycles, then exactly one pulse.
REQ-032 SHALL check: four btnU presses from reset -> sel 00->01->10->11->00.
REQ-033 SHALL check: btnC held 100 cycles with 2-cycle low glitch at cycle 50 -> exactly one data pulse; btnC_level stays 1.
REQ-034 SHALL check: btnU and btnC pulses same cycle with sel=01 -> data pulse while sel=01, sel=10 next cycle.
REQ-035 SHALL check: rst_n low during PRESS_WAIT count 2 -> outputs 0 immediately; after release with btnC held, one pulse after full 7-edge latency.
